// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed valid/ready FIFO.
// Geometry must match the attached 64x32 dual-port macro.
package sram_fifo_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DEPTH      = 64;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned OBUF_DEPTH = 2;

    localparam int unsigned CNT_W      = ADDR_W + 1;
    localparam int unsigned OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned CREDIT_W   = OBUF_CNT_W + 1;

    // Macro control pins are active-low.
    localparam logic SRAM_ON  = 1'b0;
    localparam logic SRAM_OFF = 1'b1;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/sram_fifo_if.sv
// Stream handshake bundle: upstream push side and downstream pop side.
interface sram_fifo_if;
    import sram_fifo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sram_fifo_obuf.sv
// Two-entry register FIFO that absorbs the macro's one-cycle read latency.
module sram_fifo_obuf
    import sram_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  word_t                 push_data,
    input  logic                  pop,
    output word_t                 head,
    output logic [OBUF_CNT_W-1:0] cnt
);

    word_t mem [OBUF_DEPTH];
    logic  wr_idx;
    logic  rd_idx;

    assign head = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + OBUF_CNT_W'(1);
                2'b01:   cnt <= cnt - OBUF_CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO built on a 1W/1R SRAM macro with a 2-entry output buffer.
// Pointer, occupancy and read-credit logic live here; the buffer is a sub-block.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sram_fifo_if.slave        bus,
    output logic [CNT_W-1:0]  level,
    output logic [ADDR_W-1:0] sram_a1,
    output word_t             sram_i1,
    output logic              sram_csb1,
    output logic              sram_web1,
    output logic              sram_oeb1,
    output logic [ADDR_W-1:0] sram_a2,
    output word_t             sram_i2,
    output logic              sram_csb2,
    output logic              sram_oeb2,
    output logic              sram_web2,
    input  word_t             sram_o2
);

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      sram_cnt;
    logic                  inflight;
    logic [OBUF_CNT_W-1:0] obuf_cnt;
    logic [CREDIT_W-1:0]   obuf_credit;
    logic                  push;
    logic                  pop;
    logic                  rd_go;

    assign bus.in_ready  = (sram_cnt != CNT_W'(DEPTH));
    assign bus.out_valid = (obuf_cnt != '0);
    assign level         = sram_cnt;

    // Gating push with rst_n keeps the write port quiet while reset is held.
    always_comb begin
        push        = bus.in_valid & bus.in_ready & rst_n;
        pop         = bus.out_valid & bus.out_ready;
        obuf_credit = CREDIT_W'(obuf_cnt) + CREDIT_W'(inflight) - CREDIT_W'(pop);
        rd_go       = (sram_cnt != '0) && (obuf_credit < CREDIT_W'(OBUF_DEPTH));
    end

    always_comb begin
        sram_a1   = wr_ptr;
        sram_i1   = bus.in_data;
        sram_csb1 = push ? SRAM_ON : SRAM_OFF;
        sram_web1 = push ? SRAM_ON : SRAM_OFF;
        sram_oeb1 = SRAM_OFF;
        sram_a2   = rd_ptr;
        sram_i2   = '0;
        sram_csb2 = rd_go ? SRAM_ON : SRAM_OFF;
        sram_oeb2 = rd_go ? SRAM_ON : SRAM_OFF;
        sram_web2 = SRAM_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_go) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            inflight <= rd_go;
            case ({push, rd_go})
                2'b10:   sram_cnt <= sram_cnt + CNT_W'(1);
                2'b01:   sram_cnt <= sram_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    sram_fifo_obuf u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (sram_o2),
        .pop       (pop),
        .head      (bus.out_data),
        .cnt       (obuf_cnt)
    );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural model of the 64x32 macro.
module tb_sram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  level;
    logic [5:0]  sram_a1;
    logic [31:0] sram_i1;
    logic        sram_csb1;
    logic        sram_web1;
    logic        sram_oeb1;
    logic [5:0]  sram_a2;
    logic [31:0] sram_i2;
    logic        sram_csb2;
    logic        sram_oeb2;
    logic        sram_web2;
    logic [31:0] sram_o2;

    sram_fifo_if bus ();

    sram_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .level     (level),
        .sram_a1   (sram_a1),
        .sram_i1   (sram_i1),
        .sram_csb1 (sram_csb1),
        .sram_web1 (sram_web1),
        .sram_oeb1 (sram_oeb1),
        .sram_a2   (sram_a2),
        .sram_i2   (sram_i2),
        .sram_csb2 (sram_csb2),
        .sram_oeb2 (sram_oeb2),
        .sram_web2 (sram_web2),
        .sram_o2   (sram_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: synchronous write on port 1, registered read on port 2.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
        if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard of accepted words plus ordering, stall-stability and hazard checks.
    logic [31:0] sb [$];
    logic        prev_stall;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) check("order", 64'(bus.out_data), 64'(sb.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
            if (!sram_csb1 && !sram_csb2) check("hazard", 64'(sram_a1 == sram_a2), 64'd0);
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_data  <= bus.out_data;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int   n;
    int   cyc;
    logic acc;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_csb1", 64'(sram_csb1), 64'd1);
        check("rst_web1", 64'(sram_web1), 64'd1);
        check("rst_csb2", 64'(sram_csb2), 64'd1);
        check("rst_oeb2", 64'(sram_oeb2), 64'd1);
        check("tie_oeb1", 64'(sram_oeb1), 64'd1);
        check("tie_web2", 64'(sram_web2), 64'd1);
        check("tie_i2", 64'(sram_i2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word latency
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("sw_csb1", 64'(sram_csb1), 64'd0);
        check("sw_web1", 64'(sram_web1), 64'd0);
        check("sw_a1", 64'(sram_a1), 64'd0);
        check("sw_i1", 64'(sram_i1), 64'hDEADBEEF);
        check("sw_no_read", 64'(sram_csb2), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sw_level1", 64'(level), 64'd1);
        check("sw_csb2", 64'(sram_csb2), 64'd0);
        check("sw_oeb2", 64'(sram_oeb2), 64'd0);
        check("sw_valid_n1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("sw_valid_n2", 64'(bus.out_valid), 64'd0);
        check("sw_level0", 64'(level), 64'd0);
        @(negedge clk);
        check("sw_valid", 64'(bus.out_valid), 64'd1);
        check("sw_data", 64'(bus.out_data), 64'hDEADBEEF);
        @(negedge clk);
        check("sw_empty", 64'(bus.out_valid), 64'd0);

        // Fill: 64 in SRAM plus 2 in the output buffer
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 66; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(i);
            @(negedge clk);
            check("fill_rdy", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus.in_data = 32'd66;
        @(negedge clk);
        check("full_rdy", 64'(bus.in_ready), 64'd0);
        check("full_level", 64'(level), 64'd64);
        check("full_csb1", 64'(sram_csb1), 64'd1);
        check("full_head_v", 64'(bus.out_valid), 64'd1);
        check("full_head", 64'(bus.out_data), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_level2", 64'(level), 64'd64);

        // Drain back-to-back
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            check("drain_v", 64'(bus.out_valid), 64'd1);
            check("drain_d", 64'(bus.out_data), 64'(i));
        end
        @(negedge clk);
        check("drain_end_v", 64'(bus.out_valid), 64'd0);
        check("drain_end_lvl", 64'(level), 64'd0);

        // Streaming 200 words across three pointer wraps
        @(posedge clk); #1;
        n = 0; cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd1000;
        while (n < 200 && cyc < 1000) begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1; cyc++;
            if (acc) begin n++; bus.in_data = 32'(1000 + n); end
        end
        bus.in_valid = 1'b0;
        check("stream_cnt", 64'(n), 64'd200);
        cyc = 0;
        while ((sb.size() != 0 || bus.out_valid) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("stream_left", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("stream_wptr", 64'(sram_a1), 64'd11);
        check("stream_rptr", 64'(sram_a2), 64'd11);

        // Random back-pressure with 1000 random words
        @(posedge clk); #1;
        n = 0; cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        while (n < 1000 && cyc < 20000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1; cyc++;
            if (acc) begin n++; bus.in_data = $urandom; end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_cnt", 64'(n), 64'd1000);
        cyc = 0;
        while ((sb.size() != 0 || bus.out_valid) && cyc < 500) begin
            @(posedge clk); #1; cyc++;
        end
        check("bp_left", 64'(sb.size()), 64'd0);

        // Reset with a read in flight and 10 words in the SRAM
        bus.out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(500 + i);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_level", 64'(level), 64'd10);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h00000BAD;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_valid", 64'(bus.out_valid), 64'd0);
        check("mid_lvl0", 64'(level), 64'd0);
        check("mid_rdy", 64'(bus.in_ready), 64'd1);
        check("mid_csb1", 64'(sram_csb1), 64'd1);
        check("mid_web1", 64'(sram_web1), 64'd1);
        check("mid_csb2", 64'(sram_csb2), 64'd1);
        check("mid_oeb2", 64'(sram_oeb2), 64'd1);
        check("mid_data", 64'(bus.out_data), 64'd0);
        repeat (2) @(posedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h12345678;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_v1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("post_v2", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("post_valid", 64'(bus.out_valid), 64'd1);
        check("post_data", 64'(bus.out_data), 64'h12345678);
        @(negedge clk);
        check("post_empty", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Streaming FIFO controller that turns one dual-port 64x32 SRAM macro (SRAM2RW64x32-class) into a valid/ready FIFO.
- Port 1 is write-only, port 2 is read-only.
- The SRAM's 1-cycle registered read is absorbed by a 2-entry output buffer, so the FIFO sustains 1 push plus 1 pop per cycle.
- Sits directly upstream of the macro: it drives all macro address/control/data inputs and consumes O2.

Parameters:
- WIDTH, 32, data word width; must equal macro word width.
- DEPTH, 64, SRAM entries; must equal macro depth.
- ADDR_W, 6, log2(DEPTH).
- OBUF_DEPTH, 2, output buffer entries; fixed at 2.

Ports:
- clk  in  1  block clock; the macro's CE1 and CE2 are tied to clk at the parent.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  WIDTH  upstream word.
- out_valid  out  1  head word valid.
- out_ready  in  1  downstream accepts the head word.
- out_data  out  WIDTH  head word.
- level  out  ADDR_W+1  words held in SRAM (0..64).
- sram_a1  out  ADDR_W  write address (= wr_ptr).
- sram_i1  out  WIDTH  write data (= in_data).
- sram_csb1  out  1  active-low select, port 1.
- sram_web1  out  1  active-low write enable, port 1.
- sram_oeb1  out  1  tied 1 (no port-1 reads).
- sram_a2  out  ADDR_W  read address (= rd_ptr).
- sram_i2  out  WIDTH  tied 0.
- sram_csb2  out  1  active-low select, port 2.
- sram_oeb2  out  1  active-low read enable, port 2.
- sram_web2  out  1  tied 1 (no port-2 writes).
- sram_o2  in  WIDTH  macro read data, valid the cycle after a read is issued.

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, sram_cnt=0, inflight=0, obuf empty.
  - Output reset values: in_ready=1, out_valid=0, out_data=0, level=0.
  - SRAM control reset values: sram_csb1=sram_web1=1, sram_csb2=sram_oeb2=1.
  - SRAM contents are undefined after reset; the pointers make them irrelevant.
- Push:
  - in_ready = (sram_cnt < DEPTH).
  - When in_valid & in_ready: sram_csb1=0 and sram_web1=0 combinationally; wr_ptr increments mod DEPTH at the clock edge.
- Read issue (rd_go):
  - rd_go = (sram_cnt > 0) & (obuf_cnt + inflight - pop < OBUF_DEPTH), where pop = out_valid & out_ready.
  - When rd_go: sram_csb2=0 and sram_oeb2=0; rd_ptr increments mod DEPTH at the clock edge.
  - inflight (1 bit) is set to rd_go at each edge.
- Capture: when inflight=1, sram_o2 is written into the obuf tail at the next edge.
- Output: out_valid = (obuf_cnt != 0); out_data is the obuf head. The obuf is a 2-entry register FIFO.
- sram_cnt counts words written but not yet read out: +1 on push, -1 on rd_go; both in one cycle leaves it unchanged. level = sram_cnt.
- Latency: a push at edge N into a fully empty FIFO gives rd_go in cycle N+1 and out_valid=1 after edge N+2.
- Throughput: in steady state with out_ready=1, one word per cycle with no bubbles.
- Boundary conditions:
  - Full (sram_cnt=64): in_ready=0; a push is ignored even if in_valid=1.
  - Empty: no read is issued.
  - Pointer wrap: 63 -> 0.
  - Same-address hazard: rd_ptr==wr_ptr only when sram_cnt is 0 or 64, so a read and a write never target one address in the same cycle.
  - A read of a word written at the previous edge is legal; the macro array is updated at that edge.
- Back-pressure: out_ready=0 with valid held keeps out_data stable. The obuf never overflows because the credit check counts the inflight read.
- Reset mid-operation:
  - An in-flight read is discarded and the obuf is flushed; all state returns to reset values asynchronously.
  - SRAM enables deassert immediately, with no spurious write.
- in_data is not required to be stable while in_ready=0.

Decomposition:
- Shared package sram_fifo_pkg holds WIDTH, DEPTH, ADDR_W and OBUF_DEPTH as constants, plus the SRAM control-pin polarity constants (active-low select/enable).
- One sub-module, sram_fifo_obuf: the 2-entry register FIFO with push/pop/count. The credit and pointer logic stays in the top level.

Test Plan:
- Single word: push 0xDEADBEEF into an empty FIFO with out_ready=1 -> out_valid rises 2 edges after the push with out_data=0xDEADBEEF; level returns to 0.
- Fill: push 0..65 with out_ready=0 -> 66 words accepted (64 in SRAM plus 2 in obuf); then in_ready=0 and level=64; a 67th push is ignored.
- Drain: after the fill, assert out_ready=1 -> words 0..65 come out in order, one per cycle with no gap; out_valid=0 after the last one.
- Streaming with wrap: push 200 incrementing words with in_valid=out_ready=1 -> outputs are in order; pointers wrap 3 times; sram_csb1 and sram_csb2 are never low at the same address.
- Back-pressure: toggle out_ready randomly at 50% while pushing 1000 random words -> no loss, duplication or reordering; out_data stable while stalled.
- Reset mid-stream: assert rst_n=0 with inflight=1 and 10 words stored -> out_valid=0, level=0, in_ready=1 immediately; the next push of 0x12345678 is the first word out.
